// File: rtl/cmp_pipe_pkg.sv
// Shared processor package: data/tag widths and the ALU zero-detect reduction cell.
package cmp_pipe_pkg;

   localparam int DATA_W    = 32;
   localparam int TAG_W_DEF = 5;

   // ALU reduction cell: balanced 5-level 2-input OR tree over a 32-bit word.
   function automatic logic alu_or_reduce32(input logic [31:0] v);
      logic [15:0] l1;
      logic [7:0]  l2;
      logic [3:0]  l3;
      logic [1:0]  l4;
      for (int i = 0; i < 16; i++) l1[i] = v[2*i]  | v[2*i+1];
      for (int i = 0; i < 8;  i++) l2[i] = l1[2*i] | l1[2*i+1];
      for (int i = 0; i < 4;  i++) l3[i] = l2[2*i] | l2[2*i+1];
      for (int i = 0; i < 2;  i++) l4[i] = l3[2*i] | l3[2*i+1];
      return l4[0] | l4[1];
   endfunction

endpackage

// File: rtl/cmp_pipe_stage.sv
// Generic valid/ready pipeline register: advances when empty or when downstream advances.
module cmp_pipe_stage #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [W-1:0] in_data,
   input  logic         down_adv,
   output logic         adv,
   output logic         valid,
   output logic [W-1:0] data
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   // Valid follows the upstream valid whenever the stage advances, so it drops
   // when content leaves and nothing replaces it.
   always_comb begin
      adv     = !valid_q || down_adv;
      valid_d = valid_q;
      data_d  = data_q;
      if (adv) begin
         valid_d = in_valid;
         if (in_valid) data_d = in_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/cmp_pipe.sv
// Two-stage signed compare pipeline: stage 1 subtracts, stage 2 derives ne/lt flags.
module cmp_pipe
   import cmp_pipe_pkg::*;
#(
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_a,
   input  logic [DATA_W-1:0] in_b,
   input  logic [TAG_W-1:0]  in_tag,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_ne,
   output logic              out_lt,
   output logic [DATA_W-1:0] out_diff,
   output logic              out_ovf,
   output logic [TAG_W-1:0]  out_tag,
   output logic [15:0]       cmp_count
);

   localparam int S1_W = DATA_W + 1 + TAG_W;
   localparam int S2_W = 2 + DATA_W + 1 + TAG_W;

   logic [DATA_W-1:0] s1_diff_in;
   logic              s1_ovf_in;
   logic [S1_W-1:0]   s1_in, s1_data;
   logic              s1_adv, s1_valid;

   logic [DATA_W-1:0] s1_diff;
   logic              s1_ovf;
   logic [TAG_W-1:0]  s1_tag;
   logic [S2_W-1:0]   s2_in, s2_data;
   logic              s2_adv, s2_valid;

   logic [15:0]       cmp_count_q, cmp_count_d;

   // Overflow: operand signs differ and the result sign differs from A.
   always_comb begin
      s1_diff_in = in_a + ~in_b + DATA_W'(1);
      s1_ovf_in  = (in_a[DATA_W-1] != in_b[DATA_W-1]) && (s1_diff_in[DATA_W-1] != in_a[DATA_W-1]);
      s1_in      = {s1_diff_in, s1_ovf_in, in_tag};
   end

   cmp_pipe_stage #(.W(S1_W)) u_s1 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (s1_in),
      .down_adv (s2_adv),
      .adv      (s1_adv),
      .valid    (s1_valid),
      .data     (s1_data)
   );

   always_comb begin
      {s1_diff, s1_ovf, s1_tag} = s1_data;
      s2_in = {alu_or_reduce32(s1_diff), s1_diff[DATA_W-1] ^ s1_ovf, s1_diff, s1_ovf, s1_tag};
   end

   cmp_pipe_stage #(.W(S2_W)) u_s2 (
      .clk      (clk),
      .rst      (rst),
      .in_valid (s1_valid),
      .in_data  (s2_in),
      .down_adv (out_ready),
      .adv      (s2_adv),
      .valid    (s2_valid),
      .data     (s2_data)
   );

   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;
   assign {out_ne, out_lt, out_diff, out_ovf, out_tag} = s2_data;

   always_comb begin
      cmp_count_d = cmp_count_q;
      if (s2_valid && out_ready && cmp_count_q != 16'hFFFF)
         cmp_count_d = cmp_count_q + 16'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cmp_count_q <= 16'd0;
      else     cmp_count_q <= cmp_count_d;
   end

   assign cmp_count = cmp_count_q;

endmodule

// File: tb/tb_cmp_pipe.sv
// Self-checking bench for cmp_pipe: scoreboard of expected results plus directed corner cases.
module tb_cmp_pipe;

   localparam int TW = 5;
   localparam int RW = 3 + 32 + TW;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [31:0]   in_a = '0;
   logic [31:0]   in_b = '0;
   logic [TW-1:0] in_tag = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_ne, out_lt, out_ovf;
   logic [31:0]   out_diff;
   logic [TW-1:0] out_tag;
   logic [15:0]   cmp_count;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int acc_cnt = 0;
   logic [15:0]   exp_count = 16'd0;
   logic [RW-1:0] exp_q[$];
   logic [RW-1:0] held;
   bit            hold_pend = 0;
   bit            rand_done = 0;

   cmp_pipe #(.TAG_W(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ne    (out_ne),
      .out_lt    (out_lt),
      .out_diff  (out_diff),
      .out_ovf   (out_ovf),
      .out_tag   (out_tag),
      .cmp_count (cmp_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #2000000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [TW-1:0] t);
      longint sd;
      logic   ovf;
      sd  = longint'($signed(a)) - longint'($signed(b));
      ovf = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
      return {a != b, $signed(a) < $signed(b), ovf, a - b, t};
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [RW-1:0] obs;
      logic [RW-1:0] e;
      if (rst) begin
         hold_pend = 0;
      end else begin
         obs = {out_ne, out_lt, out_ovf, out_diff, out_tag};
         check_eq("count", 64'(cmp_count), 64'(exp_count));
         if (hold_pend) check_eq("hold", 64'(obs), 64'(held));
         if (in_valid && in_ready) begin
            exp_q.push_back(model(in_a, in_b, in_tag));
            acc_cnt++;
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("spurious", 64'(obs), 64'(0));
            end else begin
               e = exp_q.pop_front();
               check_eq("result", 64'(obs), 64'(e));
            end
            if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
         end
         hold_pend = out_valid && !out_ready;
         held      = obs;
      end
   end

   task automatic drive_one(input logic [31:0] a, input logic [31:0] b, input logic [TW-1:0] t);
      int  n;
      bit  done;
      in_valid = 1'b1;
      in_a = a;
      in_b = b;
      in_tag = t;
      n = 0;
      done = 0;
      while (!done && n < 50) begin
         @(negedge clk);
         if (in_ready) done = 1;
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      if (!done) check_eq("in_timeout", 64'(0), 64'(1));
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("drain", 64'(exp_q.size()), 64'(0));
   endtask

   initial begin
      int c0;
      bit acc;
      int base;

      // Reset state, checked before any clock edge
      #1 rst = 1'b1;
      #1;
      check_eq("rst_out_valid", 64'(out_valid), 64'(0));
      check_eq("rst_count", 64'(cmp_count), 64'(0));
      check_eq("rst_in_ready", 64'(in_ready), 64'(1));
      check_eq("rst_outs", 64'({out_ne, out_lt, out_ovf, out_diff, out_tag}), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("post_rst_in_ready", 64'(in_ready), 64'(1));

      // Latency of exactly two cycles
      out_ready = 1'b1;
      drive_one(32'd5, 32'd5, 5'd3);
      check_eq("lat_early", 64'(out_valid), 64'(0));
      @(posedge clk);
      #1;
      check_eq("lat_valid", 64'(out_valid), 64'(1));
      check_eq("eq_ne", 64'(out_ne), 64'(0));
      check_eq("eq_lt", 64'(out_lt), 64'(0));
      check_eq("eq_diff", 64'(out_diff), 64'(0));
      check_eq("eq_tag", 64'(out_tag), 64'(3));
      @(posedge clk);
      #1;
      check_eq("lat_gone", 64'(out_valid), 64'(0));

      // Sign and overflow boundaries
      drive_one(32'hFFFF_FFFF, 32'd1, 5'd7);
      @(posedge clk);
      #1;
      check_eq("m1_flags", 64'({out_ne, out_lt, out_ovf}), 64'(3'b110));
      check_eq("m1_diff", 64'(out_diff), 64'(32'hFFFF_FFFE));
      drive_one(32'h8000_0000, 32'd1, 5'd8);
      @(posedge clk);
      #1;
      check_eq("min_flags", 64'({out_ne, out_lt, out_ovf}), 64'(3'b111));
      check_eq("min_diff", 64'(out_diff), 64'(32'h7FFF_FFFF));
      drive_one(32'h7FFF_FFFF, 32'hFFFF_FFFF, 5'd9);
      @(posedge clk);
      #1;
      check_eq("max_flags", 64'({out_ne, out_lt, out_ovf}), 64'(3'b101));
      check_eq("max_diff", 64'(out_diff), 64'(32'h8000_0000));
      wait_drain();

      // Asynchronous reset with two results in flight
      drive_one(32'd10, 32'd20, 5'd1);
      drive_one(32'd30, 32'd20, 5'd2);
      #3 rst = 1'b1;
      exp_q.delete();
      exp_count = 16'd0;
      #1;
      check_eq("arst_out_valid", 64'(out_valid), 64'(0));
      check_eq("arst_count", 64'(cmp_count), 64'(0));
      check_eq("arst_in_ready", 64'(in_ready), 64'(1));
      check_eq("arst_outs", 64'({out_ne, out_lt, out_ovf, out_diff, out_tag}), 64'(0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_eq("arst_no_stale", 64'(out_valid), 64'(0));

      // Ten back-to-back inputs at full rate
      c0 = cyc;
      for (int i = 0; i < 10; i++) drive_one(32'(i), 32'd4, TW'(i));
      check_eq("b2b_rate", 64'(cyc - c0), 64'(10));
      repeat (2) @(posedge clk);
      #1;
      check_eq("b2b_empty", 64'(exp_q.size()), 64'(0));
      check_eq("b2b_count", 64'(cmp_count), 64'(10));

      // Output stall with input held valid
      out_ready = 1'b0;
      base = acc_cnt;
      in_valid = 1'b1;
      in_a = $urandom;
      in_b = $urandom;
      in_tag = TW'($urandom_range(0, 31));
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            in_a = $urandom;
            in_b = $urandom;
            in_tag = TW'($urandom_range(0, 31));
         end
      end
      check_eq("stall_accepts", 64'(acc_cnt - base), 64'(2));
      check_eq("stall_in_ready", 64'(in_ready), 64'(0));
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_drain();
      check_eq("stall_count", 64'(cmp_count), 64'(12));

      // Random traffic with random backpressure
      rand_done = 0;
      fork
         begin
            for (int i = 0; i < 60; i++) begin
               drive_one($urandom, $urandom, TW'($urandom_range(0, 31)));
               if ($urandom_range(0, 3) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
         end
      join
      out_ready = 1'b1;
      wait_drain();

      // Saturation of the delivered-result counter
      @(negedge clk);
      #2;
      force dut.cmp_count_q = 16'hFFFE;
      #1;
      release dut.cmp_count_q;
      exp_count = 16'hFFFE;
      @(posedge clk);
      #1;
      for (int i = 0; i < 3; i++) drive_one(32'(i * 7), 32'd3, TW'(i));
      wait_drain();
      check_eq("sat_count", 64'(cmp_count), 64'(16'hFFFF));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cmp_pipe.md
CMP_PIPE -- requirements
Module: cmp_pipe

Interface
REQ-001 Parameter TAG_W, default 5: width of the tag carried alongside each operand pair (destination register index).
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair present on in_a/in_b/in_tag.
REQ-005 in_ready  output  1  stage 1 can accept; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-006 in_a  input  32  operand A, two's complement.
REQ-007 in_b  input  32  operand B, two's complement.
REQ-008 in_tag  input  TAG_W  opaque tag.
REQ-009 out_valid  output  1  result present on out_*.
REQ-010 out_ready  input  1  consumer accepts; transfer occurs when out_valid and out_ready are both high at a rising edge.
REQ-011 out_ne  output  1  A != B.
REQ-012 out_lt  output  1  A < B, signed.
REQ-013 out_diff  output  32  A - B, modulo 2^32.
REQ-014 out_ovf  output  1  signed overflow of A - B.
REQ-015 out_tag  output  TAG_W  tag of this result.
REQ-016 cmp_count  output  16  count of results delivered since reset, saturating.

Function
REQ-017 Stage 1 SHALL register diff = A + ~B + 1 (32 bits) and ovf = (A[31] != B[31]) && (diff[31] != A[31]), together with the tag, on an accepted input.
REQ-018 Stage 2 SHALL register ne = OR of all 32 diff bits, computed as a balanced 5-level 2-input OR tree, and lt = diff[31] XOR ovf, plus diff, ovf and tag from stage 1.
REQ-019 out_* SHALL be driven directly from stage 2 registers, with no combinational path from in_a/in_b to out_*.
REQ-020 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high.
REQ-021 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-022 Advance rules:
  - s2_adv = !s2_valid || out_ready
  - s1_adv = !s1_valid || s2_adv
  - in_ready = s1_adv
REQ-023 When out_valid is high and out_ready is low, all out_* SHALL hold stable, and no accepted input SHALL be dropped or duplicated.
REQ-024 Stage valid bits SHALL clear when their content moves on and no new data enters.
REQ-025 Payload registers SHALL load only when their stage advances.
REQ-026 A simultaneous output transfer and input transfer in the same cycle SHALL shift both stages with no bubble.
REQ-027 cmp_count SHALL increment by 1 on each output transfer.
REQ-028 cmp_count SHALL stop at 16'hFFFF and never wrap.
REQ-029 Boundary cases SHALL give correct flags:
  - A = 0x80000000, B = 1: ovf = 1, lt = 1.
  - A = 0x7FFFFFFF, B = 0xFFFFFFFF: ovf = 1, lt = 0.

Reset
REQ-030 While reset is high, s1_valid, s2_valid, out_valid and cmp_count SHALL be 0 immediately, independent of clock.
REQ-031 While reset is high, out_ne, out_lt, out_ovf, out_diff and out_tag SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight results, which are never delivered.
REQ-033 in_ready SHALL be 1 during and after reset.

Structure
REQ-034 The TAG_W default and the 32-bit data width SHALL live in the shared processor package.
REQ-035 The zero-detect OR tree SHALL be reused from the existing ALU reduction cell, not re-coded.
REQ-036 One sub-module, cmp_pipe_stage, SHALL implement a generic valid/ready pipeline register and be instantiated twice.

Verification
REQ-037 A=5, B=5, tag=3, out_ready=1 -> 2 cycles later: out_valid=1, ne=0, lt=0, diff=0, tag=3.
REQ-038 A=0xFFFFFFFF (-1), B=1 -> ne=1, lt=1, diff=0xFFFFFFFE, ovf=0; A=0x80000000, B=1 -> ovf=1, lt=1, diff=0x7FFFFFFF.
REQ-039 10 back-to-back inputs (A=i, B=4) with out_ready=1 -> 10 consecutive outputs in order, lt=1 for i<4 only, cmp_count=10.
REQ-040 out_ready low for 5 cycles with in_valid high -> in_ready=0 after 2 accepts, outputs held stable, then in-order drain with no loss or duplication.
REQ-041 Reset pulsed asynchronously between clock edges with 2 results in flight -> out_valid=0 and cmp_count=0 immediately; no stale result appears after release.
REQ-042 cmp_count preloaded via force to 0xFFFE, then 3 output transfers -> cmp_count=0xFFFF, no wrap.
